clken_reset_ctrl: RTL and testbench

//  Parametrised clock-enable and reset controller for FPGA CPU systems; replaces the ad-hoc
//  per-board button synchroniser and fixed slow-clock divider. It debounces the reset and

---
 rtl/clken_reset_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_clken_reset_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/clken_reset_ctrl.sv
// Button debouncing, stretched system reset and programmable clock-enable pulses
// (with a single-step mode) for FPGA CPU systems.
module clken_reset_ctrl #(
   parameter int               N_CH        = 2,
   parameter int               DIV_W       = 20,
   parameter logic [DIV_W-1:0] DIV_DEFAULT = '1,
   parameter int               SYNC_STAGES = 2,
   parameter int               DEB_CNT     = 1000,
   parameter int               RST_STRETCH = 16,
   parameter bit               BTN_ACT_LOW = 1'b1
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         btn_rst_raw,
   input  logic                                         btn_step_raw,
   input  logic                                         step_mode,
   input  logic                                         div_load,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]   div_ch,
   input  logic [DIV_W-1:0]                             div_val,
   output logic [N_CH-1:0]                              clk_en,
   output logic                                         sys_rst,
   output logic                                         heartbeat
);

   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int DEB_W = $clog2(DEB_CNT + 1);
   localparam int STR_W = $clog2(RST_STRETCH + 1);
   localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{BTN_ACT_LOW}};

   typedef enum logic [1:0] {
      ST_ASSERT,
      ST_STRETCH,
      ST_RUN
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [STR_W-1:0]  str_cnt;
   logic [STR_W-1:0]  str_cnt_next;
   logic [1:0]        btn_raw;
   logic [1:0]        btn_deb;
   logic              rst_src;
   logic              run_ok;
   logic              step_prev;
   logic              step_rise;
   logic [N_CH-1:0]   en_d;

   assign btn_raw = {btn_step_raw, btn_rst_raw};

   // Bit 0 is the reset button, bit 1 the step button; both normalised to 1 = pressed.
   for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic [SYNC_STAGES-1:0] sync_q;
      logic [DEB_W-1:0]       deb_cnt;
      logic                   deb_q;
      logic                   synced;

      assign synced      = sync_q[SYNC_STAGES-1] ^ BTN_ACT_LOW;
      assign btn_deb[gi] = deb_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            sync_q  <= SYNC_IDLE;
            deb_cnt <= '0;
            deb_q   <= 1'b0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[gi]};
            if (synced == deb_q) begin
               deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CNT - 1)) begin
               deb_q   <= synced;
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + 1'b1;
            end
         end
      end
   end

   assign rst_src   = btn_deb[0];
   assign step_rise = btn_deb[1] & ~step_prev;
   assign run_ok    = (state == ST_RUN) && !rst_src;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_ASSERT;
         str_cnt <= '0;
      end else begin
         state   <= state_next;
         str_cnt <= str_cnt_next;
      end
   end

   // The cycle that leaves ASSERT already counts as the first stretch cycle.
   always_comb begin
      state_next   = state;
      str_cnt_next = str_cnt;
      case (state)
         ST_ASSERT: begin
            str_cnt_next = '0;
            if (!rst_src) begin
               state_next   = (RST_STRETCH == 1) ? ST_RUN : ST_STRETCH;
               str_cnt_next = STR_W'(1);
            end
         end
         ST_STRETCH: begin
            if (rst_src) begin
               state_next   = ST_ASSERT;
               str_cnt_next = '0;
            end else if (str_cnt == STR_W'(RST_STRETCH - 1)) begin
               state_next   = ST_RUN;
               str_cnt_next = '0;
            end else begin
               str_cnt_next = str_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            str_cnt_next = '0;
            if (rst_src) begin
               state_next = ST_ASSERT;
            end
         end
         default: begin
            state_next   = ST_ASSERT;
            str_cnt_next = '0;
         end
      endcase
   end

   always_comb begin
      sys_rst = (state != ST_RUN);
   end

   for (genvar gc = 0; gc < N_CH; gc++) begin : g_ch
      localparam logic [CH_W-1:0] CH_IDX = CH_W'(gc);

      logic [DIV_W-1:0] div_q;
      logic [DIV_W-1:0] cnt_q;
      logic [DIV_W-1:0] cnt_d;
      logic             en_q;
      logic             en_next;
      logic             load_hit;

      assign load_hit   = div_load && (div_ch == CH_IDX);
      assign en_d[gc]   = en_next;
      assign clk_en[gc] = en_q;

      // Priority: held in reset, then load, then step/count.
      always_comb begin
         cnt_d   = cnt_q;
         en_next = 1'b0;
         if (!run_ok || load_hit) begin
            cnt_d = '0;
         end else if (step_mode) begin
            en_next = step_rise;
         end else if (cnt_q == div_q) begin
            cnt_d   = '0;
            en_next = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            div_q <= DIV_DEFAULT;
            cnt_q <= '0;
            en_q  <= 1'b0;
         end else begin
            if (load_hit) begin
               div_q <= div_val;
            end
            cnt_q <= cnt_d;
            en_q  <= en_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         step_prev <= 1'b0;
         heartbeat <= 1'b0;
      end else begin
         step_prev <= btn_deb[1];
         if (en_d[0]) begin
            heartbeat <= ~heartbeat;
         end
      end
   end

endmodule

// File: tb/tb_clken_reset_ctrl.sv
// Directed bench for clken_reset_ctrl: every cycle's expected outputs are queued when
// the inputs are driven and compared one clock later.
module tb_clken_reset_ctrl;

   localparam int N_CH        = 2;
   localparam int DIV_W       = 20;
   localparam int DEB_CNT     = 1000;
   localparam int RST_STRETCH = 16;
   localparam int SYNC_STAGES = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              btn_rst_raw;
   logic              btn_step_raw;
   logic              step_mode;
   logic              div_load;
   logic [0:0]        div_ch;
   logic [DIV_W-1:0]  div_val;
   logic [N_CH-1:0]   clk_en;
   logic              sys_rst;
   logic              heartbeat;

   typedef struct {
      string           tag;
      int              idx;
      logic [N_CH-1:0] en;
      logic            rst;
      logic            hb;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   logic hb_model = 1'b0;

   clken_reset_ctrl #(
      .N_CH        (N_CH),
      .DIV_W       (DIV_W),
      .DIV_DEFAULT ('1),
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CNT     (DEB_CNT),
      .RST_STRETCH (RST_STRETCH),
      .BTN_ACT_LOW (1'b1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_rst_raw  (btn_rst_raw),
      .btn_step_raw (btn_step_raw),
      .step_mode    (step_mode),
      .div_load     (div_load),
      .div_ch       (div_ch),
      .div_val      (div_val),
      .clk_en       (clk_en),
      .sys_rst      (sys_rst),
      .heartbeat    (heartbeat)
   );

   always #5 clk = ~clk;

   // Buttons are active-low on the raw pins.
   task automatic apply_stimulus(input logic por, input logic rbtn, input logic sbtn,
                                 input logic smode, input logic load, input logic ch,
                                 input logic [DIV_W-1:0] val);
      reset        = por;
      btn_rst_raw  = ~rbtn;
      btn_step_raw = ~sbtn;
      step_mode    = smode;
      div_load     = load;
      div_ch       = ch;
      div_val      = val;
   endtask

   task automatic expect_out(input string tag, input int idx, input logic por,
                             input logic [N_CH-1:0] en, input logic rst);
      exp_t e;
      if (por) hb_model = 1'b0;
      else if (en[0]) hb_model = ~hb_model;
      e.tag = tag;
      e.idx = idx;
      e.en  = en;
      e.rst = rst;
      e.hb  = hb_model;
      sb_q.push_back(e);
   endtask

   task automatic check_output();
      exp_t e;
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      assert (clk_en === e.en) else begin
         errors++;
         $error("[TB] FAIL %s[%0d] clk_en: got %b, expected %b", e.tag, e.idx, clk_en, e.en);
      end
      checks++;
      assert (sys_rst === e.rst) else begin
         errors++;
         $error("[TB] FAIL %s[%0d] sys_rst: got %b, expected %b", e.tag, e.idx, sys_rst, e.rst);
      end
      checks++;
      assert (heartbeat === e.hb) else begin
         errors++;
         $error("[TB] FAIL %s[%0d] heartbeat: got %b, expected %b", e.tag, e.idx, heartbeat, e.hb);
      end
   endtask

   task automatic run_cycle(input string tag, input int idx, input logic por,
                            input logic rbtn, input logic sbtn, input logic smode,
                            input logic load, input logic ch, input logic [DIV_W-1:0] val,
                            input logic [N_CH-1:0] exp_en, input logic exp_rst);
      apply_stimulus(por, rbtn, sbtn, smode, load, ch, val);
      expect_out(tag, idx, por, exp_en, exp_rst);
      check_output();
   endtask

   initial begin
      $display("[TB] start");

      // Power-on reset for three cycles, then the full stretch.
      for (int k = 1; k <= 3; k++)
         run_cycle("por", k, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0, 2'b00, 1'b1);
      for (int j = 1; j <= 24; j++)
         run_cycle("stretch", j, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0, 2'b00,
                   (j < RST_STRETCH));

      // 999-cycle reset press is a glitch; a step press outside step mode does nothing.
      for (int k = 1; k <= 1120; k++)
         run_cycle("glitch", k, 1'b0, (k <= 999), (k <= 1100), 1'b0, 1'b0, 1'b0, 20'd0,
                   2'b00, 1'b0);

      // 1500-cycle reset press: rises SYNC_STAGES+DEB_CNT+1 after press.
      for (int k = 1; k <= 1500; k++)
         run_cycle("rst_press", k, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0, 2'b00,
                   (k >= SYNC_STAGES + DEB_CNT + 1));
      for (int k = 1; k <= 1030; k++)
         run_cycle("rst_release", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0, 2'b00,
                   (k < SYNC_STAGES + DEB_CNT + RST_STRETCH));

      // div[0]=3 then div[1]=0.
      for (int t = 0; t <= 20; t++)
         run_cycle("div_3_0", t, 1'b0, 1'b0, 1'b0, 1'b0, (t <= 1), (t == 1),
                   (t == 0) ? 20'd3 : 20'd0,
                   {(t >= 2), (t != 0 && t % 4 == 0)}, 1'b0);

      // div[0]=9, reloaded to 2 five cycles later.
      for (int t = 0; t <= 20; t++)
         run_cycle("reload", t, 1'b0, 1'b0, 1'b0, 1'b0, (t == 0 || t == 5), 1'b0,
                   (t == 0) ? 20'd9 : 20'd2,
                   {1'b1, (t > 5 && (t - 5) % 3 == 0)}, 1'b0);

      // div[0]=4, let ch0 reach count 2, then freeze in step mode.
      for (int t = 0; t <= 2; t++)
         run_cycle("pre_step", t, 1'b0, 1'b0, 1'b0, 1'b0, (t == 0), 1'b0, 20'd4,
                   2'b10, 1'b0);
      for (int n = 0; n < 3; n++) begin
         for (int q = 1; q <= 1010; q++)
            run_cycle("step_press", n * 10000 + q, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'd0,
                      (q == SYNC_STAGES + DEB_CNT + 1) ? 2'b11 : 2'b00, 1'b0);
         for (int q = 1; q <= 1010; q++)
            run_cycle("step_release", n * 10000 + q, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                      20'd0, 2'b00, 1'b0);
      end

      // Leaving step mode resumes ch0 from its frozen count of 2.
      for (int u = 0; u <= 15; u++)
         run_cycle("resume", u, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0,
                   {1'b1, (u >= 2 && (u - 2) % 5 == 0)}, 1'b0);

      // Power-on reset pulse mid-run reloads the defaults; a load during stretch sticks.
      run_cycle("por_pulse", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0, 2'b00, 1'b1);
      for (int v = 1; v <= 40; v++)
         run_cycle("after_por", v, 1'b0, 1'b0, 1'b0, 1'b0, (v == 5), 1'b1, 20'd0,
                   {(v >= RST_STRETCH + 1), 1'b0}, (v < RST_STRETCH));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
